pmem_line_responder: RTL
========================

Name: pmem_line_responder

Overview:
- Responder end of the cache-to-physical-memory line interface; the cache controller is the initiator.
- Accepts whole-line reads and writes on pmem_read/pmem_write/pmem_address and returns a single-cycle pmem_resp after a fixed, parameterised latency.
- Backs requests with an internal line array that is zeroed after reset.
- Used as the synthesizable memory stand-in for cache bring-up and as the reference responder in cache benches.

Parameters:
- S_OFFSET, 5, byte-offset bits per line; line = 2**S_OFFSET bytes.
- S_LINE, 256, line width in bits; must equal 8*2**S_OFFSET.
- IDX_BITS, 4, line-index bits; array holds 2**IDX_BITS lines.
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..255.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pmem_read  in  1  line read request, held until pmem_resp.
- pmem_write  in  1  line write request, held until pmem_resp.
- pmem_address  in  32  line address; bits [S_OFFSET-1:0] ignored.
- pmem_wdata  in  S_LINE  write line data.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  S_LINE  read line data, valid in the pmem_resp cycle of a read.
- init_done  out  1  high once post-reset clear sweep finishes.
- protocol_err  out  1  sticky request-protocol violation flag.

Behaviour:
- Reset (rst_n low at an edge):
  - state becomes INIT; index counter and latency counter are 0.
  - pmem_resp=0, pmem_rdata=0, init_done=0, protocol_err=0.
  - Any in-flight request is dropped with no response and no commit.
- Line index = pmem_address[S_OFFSET+IDX_BITS-1:S_OFFSET]. Upper address bits alias.
- States:
  - INIT: writes zero to line[counter], one line per cycle. After line 2**IDX_BITS-1 is cleared, go to IDLE and set init_done=1; init_done stays 1 until the next reset. Requests are ignored (not accepted) in INIT.
  - IDLE: a request is accepted at an edge where pmem_read or pmem_write is high. On acceptance:
    - latch op, index and wdata;
    - load latency counter with LATENCY-1;
    - go to BUSY if LATENCY>1, else to RESP.
  - BUSY: decrements the counter each cycle; goes to RESP when the counter reaches 0.
  - RESP:
    - pmem_resp=1 for exactly this one cycle.
    - Read: pmem_rdata holds line[latched index], registered on entry to RESP.
    - Write: the latched wdata is committed to the array on the edge entering RESP.
    - Next state is always IDLE.
- Timing: a request first high in cycle 0 while IDLE produces pmem_resp in cycle LATENCY only (LATENCY=4 gives a pulse in cycle 4).
- pmem_rdata holds its last value until the next read response; it is unchanged by writes.
- IDLE occupies at least one cycle between responses. A requester that drops its request after resp and raises a new one next cycle (write-back then fill) is accepted in that cycle; no bubble beyond IDLE is required.
- A write followed by a read of the same index returns the written data (commit precedes any later read capture).
- protocol_err is set (sticky until reset) when any of the following occurs:
  - pmem_read and pmem_write are both high at acceptance; the request is treated as a write.
  - The request drops while in BUSY; the responder returns to IDLE with no resp and no commit.
  - pmem_address index or op changes while in BUSY; the latched values are used regardless.
- A request held high through RESP is not re-accepted in RESP. It is re-accepted in IDLE only if still high there; a compliant initiator deasserts.

Test Plan:
- Reset then 16 idle cycles → init_done rises after exactly 16 cycles of INIT; a read of index 0x3 returns all-zero rdata and pmem_resp in cycle 4 after the request.
- Write 0xA5 repeated to address 0x0000_0060 (index 3), then read 0x0000_0060 → resp in cycle 4 of each request; read returns 0xA5 repeated; protocol_err=0.
- Back-to-back write index 5 then read index 5 the cycle after the write's resp → read accepted immediately; returns the written line; rdata unchanged during the write's resp.
- Alias: write to 0x0000_0020, read 0x0000_0220 (same index 1, IDX_BITS=4) → same data returned.
- Abort: assert pmem_read, drop it in cycle 2 with LATENCY=4 → no pmem_resp; protocol_err=1; a subsequent read completes normally.
- Both read and write high, and reset asserted mid-BUSY → the first case commits as a write with protocol_err=1; the reset case yields no resp, re-runs INIT, and protocol_err=0.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Responder end of the cache-to-pmem line interface: whole-line reads/writes
// from an internal line array, answered with a one-cycle pmem_resp after LATENCY cycles.
module pmem_line_responder #(
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = 256,
  parameter int IDX_BITS = 4,
  parameter int LATENCY  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [S_LINE-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [S_LINE-1:0] pmem_rdata,
  output logic              init_done,
  output logic              protocol_err
);

  typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

  localparam int            LINES    = 2 ** IDX_BITS;
  localparam logic [7:0]    LAT_LOAD = 8'(LATENCY - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LINES - 1);

  state_t state_reg, state_next;

  logic [S_LINE-1:0]   mem [LINES];
  logic [IDX_BITS-1:0] init_cnt_reg;
  logic [7:0]          lat_cnt_reg;
  logic                op_write_reg;
  logic [IDX_BITS-1:0] idx_reg;
  logic [S_LINE-1:0]   wdata_reg;

  logic                req;
  logic [IDX_BITS-1:0] addr_idx;
  logic                addr_unused;

  logic                entering_resp;
  logic                op_write_now;
  logic                mem_we;
  logic                rd_capture;
  logic [IDX_BITS-1:0] mem_addr;
  logic [S_LINE-1:0]   mem_din;

  assign req         = pmem_read | pmem_write;
  assign addr_idx    = pmem_address[S_OFFSET+IDX_BITS-1:S_OFFSET];
  assign addr_unused = ^{pmem_address[31:S_OFFSET+IDX_BITS], pmem_address[S_OFFSET-1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= INIT;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT: if (init_cnt_reg == LAST_IDX) state_next = IDLE;
      IDLE: if (req) state_next = (LATENCY > 1) ? BUSY : RESP;
      BUSY: begin
        if (!req)                    state_next = IDLE;
        else if (lat_cnt_reg == 8'd1) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Outputs and array port control; in IDLE (LATENCY=1 case) the live request
  // is used because nothing has been latched yet.
  always_comb begin
    pmem_resp     = (state_reg == RESP);
    entering_resp = (state_reg != RESP) && (state_next == RESP);
    op_write_now  = (state_reg == IDLE) ? pmem_write : op_write_reg;
    mem_we        = 1'b0;
    rd_capture    = 1'b0;
    mem_addr      = (state_reg == IDLE) ? addr_idx : idx_reg;
    mem_din       = (state_reg == IDLE) ? pmem_wdata : wdata_reg;
    if (state_reg == INIT) begin
      mem_we   = 1'b1;
      mem_addr = init_cnt_reg;
      mem_din  = '0;
    end else if (entering_resp) begin
      mem_we     = op_write_now;
      rd_capture = !op_write_now;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt_reg <= '0;
      lat_cnt_reg  <= '0;
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      init_done    <= 1'b0;
      protocol_err <= 1'b0;
      pmem_rdata   <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          init_cnt_reg <= init_cnt_reg + 1'b1;
          if (init_cnt_reg == LAST_IDX) init_done <= 1'b1;
        end
        IDLE: begin
          if (req) begin
            op_write_reg <= pmem_write;
            idx_reg      <= addr_idx;
            wdata_reg    <= pmem_wdata;
            lat_cnt_reg  <= LAT_LOAD;
            if (pmem_read && pmem_write) protocol_err <= 1'b1;
          end
        end
        BUSY: begin
          if (!req || (addr_idx != idx_reg) || (pmem_write != op_write_reg))
            protocol_err <= 1'b1;
          if (lat_cnt_reg != 8'd0) lat_cnt_reg <= lat_cnt_reg - 1'b1;
        end
        default: ;
      endcase
      if (rd_capture) pmem_rdata <= mem[mem_addr];
    end
  end

endmodule
